// File: rtl/prime_sieve_pkg.sv
// -----------------------------------------------------------------------------
// prime_sieve_pkg
// Shared types and default geometry for the prime sieve engine.
//   state_e : control FSM states (IDLE, RUN, FINISH)
//   lane_t  : one sieve lane record at the default width (valid, prime, multiple)
// -----------------------------------------------------------------------------
package prime_sieve_pkg;

    localparam int unsigned DEFAULT_WIDTH       = 20;
    localparam int unsigned DEFAULT_NUM_LANES   = 168;  // pi(sqrt(10^6)) = 168
    localparam int unsigned DEFAULT_CYCLE_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_FINISH = 2'd2
    } state_e;

    // Multiple is one bit wider than the prime so multiple + prime never wraps.
    typedef struct packed {
        logic                     valid;
        logic [DEFAULT_WIDTH-1:0] prime;
        logic [DEFAULT_WIDTH:0]   multiple;
    } lane_t;

endpackage

// File: rtl/sieve_lane.sv
// -----------------------------------------------------------------------------
// sieve_lane
// Holds one sieving prime and its next multiple. Flags a hit when the multiple
// equals the current candidate and steps the multiple by the prime on advance.
// Ports:
//   i_clk, i_rst_n : clock, async active-low reset
//   i_clear        : invalidate the lane (new search)
//   i_load         : capture i_prime / i_square and mark the lane valid
//   i_prime        : prime to hold
//   i_square       : first multiple to strike (prime squared)
//   i_cand         : candidate under evaluation
//   i_advance      : candidate is being consumed this cycle
//   o_valid        : lane in use
//   o_hit          : lane strikes the candidate
// -----------------------------------------------------------------------------
module sieve_lane #(
    parameter int unsigned WIDTH = 20
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clear,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_prime,
    input  logic [WIDTH:0]   i_square,
    input  logic [WIDTH-1:0] i_cand,
    input  logic             i_advance,
    output logic             o_valid,
    output logic             o_hit
);

    logic             r_valid;
    logic [WIDTH-1:0] r_prime;
    logic [WIDTH:0]   r_multiple;
    logic             w_hit;

    assign w_hit   = r_valid && (r_multiple == {1'b0, i_cand});
    assign o_valid = r_valid;
    assign o_hit   = w_hit;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_valid    <= 1'b0;
            r_prime    <= '0;
            r_multiple <= '0;
        end else if (i_clear) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid    <= 1'b1;
            r_prime    <= i_prime;
            r_multiple <= i_square;
        end else if (i_advance && w_hit) begin
            r_multiple <= r_multiple + {1'b0, r_prime};
        end
    end

endmodule

// File: rtl/prime_sieve_engine.sv
// -----------------------------------------------------------------------------
// prime_sieve_engine
// Incremental Sieve of Eratosthenes over 2..search_limit using NUM_LANES
// parallel lanes. Primes stream out ascending on a valid/ready port; the block
// also reports prime count, largest prime and busy cycle count.
// Ports:
//   i_clk, i_rst_n    : clock, async active-low reset
//   i_start           : start request (IDLE only), samples i_search_limit
//   i_search_limit    : inclusive upper bound
//   o_prime_data      : streamed prime
//   o_prime_valid     : o_prime_data valid, held until i_prime_ready
//   i_prime_ready     : consumer accept
//   o_busy            : search in progress
//   o_done            : one-cycle completion pulse
//   o_lane_overflow   : sticky, a prime needed a lane and none was free
//   o_largest_prime   : last prime found
//   o_prime_count     : primes found
//   o_elapsed_cycles  : busy cycles, saturating
// -----------------------------------------------------------------------------
module prime_sieve_engine
    import prime_sieve_pkg::*;
#(
    parameter int unsigned WIDTH       = DEFAULT_WIDTH,
    parameter int unsigned NUM_LANES   = DEFAULT_NUM_LANES,
    parameter int unsigned CYCLE_WIDTH = DEFAULT_CYCLE_WIDTH
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_start,
    input  logic [WIDTH-1:0]       i_search_limit,
    output logic [WIDTH-1:0]       o_prime_data,
    output logic                   o_prime_valid,
    input  logic                   i_prime_ready,
    output logic                   o_busy,
    output logic                   o_done,
    output logic                   o_lane_overflow,
    output logic [WIDTH-1:0]       o_largest_prime,
    output logic [WIDTH-1:0]       o_prime_count,
    output logic [CYCLE_WIDTH-1:0] o_elapsed_cycles
);

    state_e                 r_state;
    logic [WIDTH-1:0]       r_limit;
    logic [WIDTH-1:0]       r_cand;
    logic [WIDTH-1:0]       r_prime_data;
    logic                   r_prime_valid;
    logic                   r_overflow;
    logic [WIDTH-1:0]       r_largest;
    logic [WIDTH-1:0]       r_count;
    logic [CYCLE_WIDTH-1:0] r_elapsed;

    logic [NUM_LANES-1:0]   w_lane_valid;
    logic [NUM_LANES-1:0]   w_lane_hit;
    logic [NUM_LANES-1:0]   w_lane_load;
    logic [2*WIDTH-1:0]     w_square;
    logic                   w_idle_start;
    logic                   w_stall;
    logic                   w_eval;
    logic                   w_is_prime;
    logic                   w_alloc;
    logic                   w_free_found;
    logic                   w_last;
    logic                   w_busy;
    logic                   w_done;

    assign w_idle_start = (r_state == ST_IDLE) && i_start;
    assign w_stall      = r_prime_valid && !i_prime_ready;
    assign w_eval       = (r_state == ST_RUN) && !w_stall;
    assign w_is_prime   = ~|w_lane_hit;
    assign w_square     = {{WIDTH{1'b0}}, r_cand} * {{WIDTH{1'b0}}, r_cand};
    assign w_alloc      = w_eval && w_is_prime && (w_square <= {{WIDTH{1'b0}}, r_limit});
    assign w_last       = (r_cand == r_limit);
    // FINISH only waits for the last prime to drain; busy drops as done fires.
    assign w_done       = (r_state == ST_FINISH) && !r_prime_valid;
    assign w_busy       = (r_state == ST_RUN) || ((r_state == ST_FINISH) && r_prime_valid);

    // Lowest free lane takes the new prime.
    always_comb begin
        w_lane_load  = '0;
        w_free_found = 1'b0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (!w_lane_valid[i] && !w_free_found) begin
                w_lane_load[i] = w_alloc;
                w_free_found   = 1'b1;
            end
        end
    end

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        sieve_lane #(
            .WIDTH(WIDTH)
        ) u_lane (
            .i_clk    (i_clk),
            .i_rst_n  (i_rst_n),
            .i_clear  (w_idle_start),
            .i_load   (w_lane_load[g]),
            .i_prime  (r_cand),
            .i_square (w_square[WIDTH:0]),
            .i_cand   (r_cand),
            .i_advance(w_eval),
            .o_valid  (w_lane_valid[g]),
            .o_hit    (w_lane_hit[g])
        );
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= ST_IDLE;
            r_limit       <= '0;
            r_cand        <= '0;
            r_prime_data  <= '0;
            r_prime_valid <= 1'b0;
            r_overflow    <= 1'b0;
            r_largest     <= '0;
            r_count       <= '0;
            r_elapsed     <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_limit    <= i_search_limit;
                        r_cand     <= WIDTH'(2);
                        r_count    <= '0;
                        r_largest  <= '0;
                        r_elapsed  <= '0;
                        r_overflow <= 1'b0;
                        r_state    <= (i_search_limit < WIDTH'(2)) ? ST_FINISH : ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (w_eval) begin
                        // The terminal candidate never increments, so c cannot wrap.
                        if (w_last) r_state <= ST_FINISH;
                        else        r_cand  <= r_cand + WIDTH'(1);
                    end
                end
                ST_FINISH: begin
                    if (w_done) r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase

            // Output register reloads in the cycle it is accepted for full throughput.
            if (w_eval && w_is_prime) begin
                r_prime_valid <= 1'b1;
                r_prime_data  <= r_cand;
                r_count       <= r_count + WIDTH'(1);
                r_largest     <= r_cand;
            end else if (r_prime_valid && i_prime_ready) begin
                r_prime_valid <= 1'b0;
            end

            if (w_alloc && !w_free_found) r_overflow <= 1'b1;

            if (w_busy && !(&r_elapsed)) r_elapsed <= r_elapsed + CYCLE_WIDTH'(1);
        end
    end

    assign o_prime_data     = r_prime_data;
    assign o_prime_valid    = r_prime_valid;
    assign o_busy           = w_busy;
    assign o_done           = w_done;
    assign o_lane_overflow  = r_overflow;
    assign o_largest_prime  = r_largest;
    assign o_prime_count    = r_count;
    assign o_elapsed_cycles = r_elapsed;

endmodule

// File: tb/tb_prime_sieve_engine.sv
module tb_prime_sieve_engine;

    localparam int A_LANES = 4;
    localparam int B_LANES = 2;
    localparam int A_SAT   = 65535;
    localparam int B_SAT   = 63;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;

    // Per-DUT stimulus and observed outputs; index 0 = A (12b, 4 lanes), 1 = B (8b, 2 lanes).
    logic        start[2];
    logic [11:0] limit[2];
    logic        ready[2];
    int          rmode[2];
    int          pdata[2], cnt_o[2], larg_o[2], elap_o[2];
    logic        pvalid[2], busy[2], done[2], ovf[2];

    logic [11:0] a_pdata, a_largest, a_count;
    logic [15:0] a_elapsed;
    logic [7:0]  b_pdata, b_largest, b_count;
    logic [5:0]  b_elapsed;

    int q0[$];
    int q1[$];

    prime_sieve_engine #(
        .WIDTH(12), .NUM_LANES(A_LANES), .CYCLE_WIDTH(16)
    ) u_dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start[0]), .i_search_limit(limit[0]),
        .o_prime_data(a_pdata), .o_prime_valid(pvalid[0]), .i_prime_ready(ready[0]),
        .o_busy(busy[0]), .o_done(done[0]), .o_lane_overflow(ovf[0]),
        .o_largest_prime(a_largest), .o_prime_count(a_count), .o_elapsed_cycles(a_elapsed)
    );

    prime_sieve_engine #(
        .WIDTH(8), .NUM_LANES(B_LANES), .CYCLE_WIDTH(6)
    ) u_dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start[1]), .i_search_limit(limit[1][7:0]),
        .o_prime_data(b_pdata), .o_prime_valid(pvalid[1]), .i_prime_ready(ready[1]),
        .o_busy(busy[1]), .o_done(done[1]), .o_lane_overflow(ovf[1]),
        .o_largest_prime(b_largest), .o_prime_count(b_count), .o_elapsed_cycles(b_elapsed)
    );

    always_comb begin
        pdata[0]  = int'(a_pdata);
        cnt_o[0]  = int'(a_count);
        larg_o[0] = int'(a_largest);
        elap_o[0] = int'(a_elapsed);
        pdata[1]  = int'(b_pdata);
        cnt_o[1]  = int'(b_count);
        larg_o[1] = int'(b_largest);
        elap_o[1] = int'(b_elapsed);
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int q_size(input int d);
        return (d == 0) ? q0.size() : q1.size();
    endfunction

    function automatic int q_pop(input int d);
        if (d == 0) return q0.pop_front();
        return q1.pop_front();
    endfunction

    task automatic flush(input int d);
        if (d == 0) q0.delete();
        else q1.delete();
    endtask

    // Reference: c is reported prime unless divisible by a prime that got a lane;
    // lanes go to found primes with p*p <= limit in order until they run out.
    task automatic model(input int d, input int lim, output int ecnt, output int elg,
                         output bit eov, output bit lprime);
        int  alloc[$];
        int  lanes;
        bit  comp;
        lanes  = (d == 0) ? A_LANES : B_LANES;
        ecnt   = 0;
        elg    = 0;
        eov    = 0;
        lprime = 0;
        for (int c = 2; c <= lim; c++) begin
            comp = 0;
            foreach (alloc[i]) if (c % alloc[i] == 0) comp = 1;
            if (!comp) begin
                if (d == 0) q0.push_back(c);
                else q1.push_back(c);
                ecnt++;
                elg    = c;
                lprime = (c == lim);
                if (c * c <= lim) begin
                    if (alloc.size() < lanes) alloc.push_back(c);
                    else eov = 1;
                end
            end
        end
    endtask

    // Scoreboard monitor: every accepted prime must be the next expected one.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int d = 0; d < 2; d++) begin
                if (pvalid[d] && ready[d]) begin
                    if (q_size(d) == 0) check($sformatf("unexpected_prime_d%0d", d), pdata[d], -1);
                    else check($sformatf("prime_d%0d", d), pdata[d], q_pop(d));
                end
            end
        end
    end

    // Consumer: 0 = always ready, 1 = ready one cycle in three, 2 = random.
    int phase = 0;
    initial begin
        ready[0] = 1'b1;
        ready[1] = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            phase++;
            for (int d = 0; d < 2; d++) begin
                case (rmode[d])
                    1:       ready[d] = (phase % 3 == 0);
                    2:       ready[d] = ($urandom_range(0, 1) == 1);
                    default: ready[d] = 1'b1;
                endcase
            end
        end
    end

    task automatic run(input int d, input int lim, input int mode, input bit inj);
        int ecnt, elg, k0, kd, ediff, sat;
        bit eov, lprime, seen;
        model(d, lim, ecnt, elg, eov, lprime);
        sat      = (d == 0) ? A_SAT : B_SAT;
        rmode[d] = mode;
        @(negedge clk);
        start[d] = 1'b1;
        limit[d] = 12'(lim);
        @(posedge clk);
        #1;
        k0       = cyc;
        start[d] = 1'b0;
        if (inj) begin
            // Must be ignored while busy.
            repeat (3) @(negedge clk);
            start[d] = 1'b1;
            limit[d] = 12'd10;
            @(posedge clk);
            #1;
            start[d] = 1'b0;
        end
        seen = 0;
        kd   = 0;
        for (int i = 0; i < 4 * lim + 60; i++) begin
            @(negedge clk);
            if (done[d]) begin
                seen = 1;
                kd   = cyc;
                break;
            end
        end
        if (!seen) begin
            check($sformatf("done_timeout_d%0d_L%0d", d, lim), 0, 1);
            flush(d);
            rmode[d] = 0;
            return;
        end
        check($sformatf("count_d%0d_L%0d", d, lim), cnt_o[d], ecnt);
        check($sformatf("largest_d%0d_L%0d", d, lim), larg_o[d], elg);
        check($sformatf("overflow_d%0d_L%0d", d, lim), int'(ovf[d]), int'(eov));
        check($sformatf("valid_at_done_d%0d_L%0d", d, lim), int'(pvalid[d]), 0);
        check($sformatf("busy_at_done_d%0d_L%0d", d, lim), int'(busy[d]), 0);
        check($sformatf("drained_d%0d_L%0d", d, lim), q_size(d), 0);
        check($sformatf("elapsed_d%0d_L%0d", d, lim), elap_o[d], (kd - k0 > sat) ? sat : kd - k0);
        if (mode == 0) begin
            ediff = (lim < 2) ? 0 : lim - 1 + int'(lprime);
            check($sformatf("done_cycle_d%0d_L%0d", d, lim), kd - k0, ediff);
        end
        repeat (2) @(negedge clk);
        check($sformatf("hold_count_d%0d_L%0d", d, lim), cnt_o[d], ecnt);
        check($sformatf("hold_ovf_d%0d_L%0d", d, lim), int'(ovf[d]), int'(eov));
        check($sformatf("hold_done_low_d%0d_L%0d", d, lim), int'(done[d]), 0);
        flush(d);
        rmode[d] = 0;
    endtask

    task automatic reset_midrun();
        int  c, l;
        bit  o, lp, seen;
        model(0, 100, c, l, o, lp);
        rmode[0] = 0;
        @(negedge clk);
        start[0] = 1'b1;
        limit[0] = 12'd100;
        @(posedge clk);
        #1;
        start[0] = 1'b0;
        seen = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (cnt_o[0] == 5) begin
                seen = 1;
                break;
            end
        end
        check("reach_five_primes", int'(seen), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrun_reset_zero", pdata[0] | cnt_o[0] | larg_o[0] | elap_o[0] |
              int'({pvalid[0], busy[0], done[0], ovf[0]}), 0);
        q0.delete();
        @(negedge clk);
        rst_n = 1'b1;
        run(0, 100, 0, 1'b1);
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            start[d] = 1'b0;
            limit[d] = '0;
            rmode[d] = 0;
        end
        #1;
        rst_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("reset_zero_d%0d", d), pdata[d] | cnt_o[d] | larg_o[d] | elap_o[d] |
                  int'({pvalid[d], busy[d], done[d], ovf[d]}), 0);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        run(0, 10, 0, 1'b0);
        run(0, 1, 0, 1'b0);
        run(0, 2, 0, 1'b0);
        run(0, 30, 1, 1'b0);
        run(0, 0, 2, 1'b0);
        run(0, 97, 0, 1'b0);
        run(0, 200, 2, 1'b0);
        run(0, int'($urandom_range(3, 400)), 2, 1'b0);
        run(0, int'($urandom_range(3, 400)), 1, 1'b0);
        run(0, 4095, 0, 1'b0);

        run(1, 30, 0, 1'b0);
        run(1, 7, 0, 1'b0);
        run(1, 100, 2, 1'b0);
        run(1, 255, 0, 1'b0);

        reset_midrun();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/prime_sieve_engine.md
# prime_sieve_engine

Parametrised successor to the fixed ten-counter prime block. It runs an incremental Sieve of Eratosthenes over the candidates 2..search_limit, using NUM_LANES parallel sieve lanes. Each lane holds one sieving prime and that prime's next multiple. Discovered primes are streamed out on a valid/ready interface, and the block also reports the largest prime, the prime count and the elapsed cycle count. It sits between the search-limit input logic and the display/report logic.

## Interface
- WIDTH, 20: candidate and limit width; limit max 2^WIDTH-1
- NUM_LANES, 168: sieve lanes; must be ≥ π(√limit) (168 covers 10^6)
- CYCLE_WIDTH, 32: elapsed-cycle counter width
- clk  in  1  clock, rising edge
- Reset_n  in  1  asynchronous, active-low reset
- start  in  1  single-cycle request; samples search_limit; ignored unless IDLE
- search_limit  in  WIDTH  inclusive upper bound
- prime_data  out  WIDTH  streamed prime, ascending
- prime_valid  out  1  prime_data valid; held until prime_ready
- prime_ready  in  1  consumer accept
- busy  out  1  high in RUN and FINISH
- done  out  1  one-cycle pulse at completion
- lane_overflow  out  1  sticky; lanes exhausted, results unreliable
- largest_prime  out  WIDTH  last prime found; 0 if none
- prime_count  out  WIDTH  primes found
- elapsed_cycles  out  CYCLE_WIDTH  cycles spent busy; saturates at all-ones

## Operation
- Reset: state IDLE; all lanes invalid; every output 0.
- States: IDLE -> RUN on start. RUN -> FINISH after candidate == limit is evaluated. FINISH -> IDLE on the cycle prime_valid is 0, pulsing done that cycle.
- start in IDLE:
  - clears count, largest, elapsed, overflow and lanes
  - latches limit; candidate c = 2
  - limit < 2: go straight to FINISH; no primes output.
- RUN, each non-stalled cycle, all lanes compare in parallel:
  - lane hit = lane valid and multiple == c
  - c is composite if any lane hits. Every hitting lane advances multiple += p, all simultaneously (e.g. 12 advances the lanes for 2 and 3).
  - Otherwise c is prime: load output register (prime_valid=1), count++, largest=c.
  - Prime with c*c ≤ limit: allocate the lowest free lane with p=c, multiple=c*c. If no lane is free, set lane_overflow, continue the search, and allocate nothing.
  - Then c++.
- Stall: when prime_valid=1 and prime_ready=0, c, the lanes and the counters hold. Stall cycles still count in elapsed_cycles.
- Width rules:
  - c*c is computed at 2·WIDTH bits.
  - lane multiple is WIDTH+1 bits, so multiple+p never wraps.
  - c at limit 2^WIDTH-1 is the terminal candidate; c never wraps.
- Reset mid-run: immediate return to IDLE with all outputs 0; an in-flight prime is dropped.

## Timing
- start sampled at edge k: busy=1 from cycle k+1, first candidate evaluated in cycle k+1.
- Prime evaluated in cycle n appears with prime_valid=1 at cycle n+1.
- A transfer occurs when prime_valid and prime_ready are both high at an edge. The output register may reload in the same cycle it is accepted, giving 1 prime/cycle throughput.
- With prime_ready held at 1, one candidate is evaluated per cycle. For limit L ≥ 2, done pulses at cycle k+L, busy falls the same cycle, and elapsed_cycles = L-1.
- largest_prime, prime_count, elapsed_cycles and lane_overflow hold after done until the next start.
- done is never high together with prime_valid.

## Structure
- Package prime_sieve_pkg holds:
  - state enum: IDLE, RUN, FINISH
  - lane record type: valid, prime, multiple
  - default constants: WIDTH, NUM_LANES
- Sub-module sieve_lane, instantiated NUM_LANES times by generate. Each lane does:
  - lane register with load
  - equality compare against c
  - multiple+p adder
  - hit output
- Lowest-free-lane priority encoder and control FSM sit in the top level.

## Test plan
- limit=10, ready=1: stream 2,3,5,7 on consecutive-prime cycles; done at k+10; count=4, largest=7, elapsed=9, overflow=0.
- limit=1, then limit=2: first gives done with count 0, largest 0, no valid. Second streams 2 only; count=1, largest=2.
- limit=30, ready toggling 1-of-3 cycles: same 10 primes (2..29) in order, none lost or duplicated; elapsed_cycles = 29 + stall cycles.
- NUM_LANES=2, limit=30: 5 finds no free lane, lane_overflow=1 and stays sticky; 25 is streamed as prime; count=11.
- limit=1000000, ready=1: count=78498, largest=999983, overflow=0, elapsed=999999.
- Reset_n low mid-run at limit=100 after 5 primes: all outputs 0 immediately. A start while busy is ignored. A fresh start after reset gives count=25, largest=97.
